// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor controller.
package serial_add_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One extra bit so cnt can count up to WIDTH, which also keeps WIDTH=1 legal.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// Combinational one-bit full adder, time-shared by the serial controller.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: LSB-first, one bit per clock through a
// single fa_bit, with a start/busy/done handshake and registered results.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              fa_s, fa_co;
  logic              last_bit;

  fa_bit u_fa (
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == LastCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          // Subtract is a + ~b + 1: invert b once here, seed the carry with 1.
          opb_d   = sub ? ~b : b;
          carry_d = sub | cin;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        acc_d            = acc_q >> 1;
        acc_d[WIDTH-1]   = fa_s;
        opa_d            = opa_q >> 1;
        opb_d            = opb_q >> 1;
        carry_d          = fa_co;
        cnt_d            = cnt_q + CntW'(1);
        if (last_bit) begin
          sum_d  = acc_d;
          cout_d = fa_co;
          ovf_d  = carry_q ^ fa_co;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder/subtractor controller. One instance of the team's single-bit full adder is time-shared across a WIDTH-bit operation, LSB first, one bit per clock. The block registers the operands, sequences the adder, holds the carry between bits and assembles the result. It sits between a requester using a start/busy/done handshake and the one-bit full-adder datapath.

## Interface
Parameters:
- WIDTH, 8: operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock; the block uses this single clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request to begin an operation; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (a − b); sampled with start.
- a  input  WIDTH  first operand; sampled with start.
- b  input  WIDTH  second operand; sampled with start.
- cin  input  1  carry-in for add; ignored when sub=1.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held until the next completion.
- cout  output  1  carry-out. In subtract mode, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states are IDLE and RUN.
- IDLE → RUN on an edge with start=1. On that edge:
  - Latch a into opa.
  - Latch b into opb, inverted when sub=1.
  - carry ← (sub ? 1 : cin); cnt ← 0; busy ← 1.
- RUN, each edge:
  - fa_bit adds opa[0], opb[0] and carry.
  - The sum bit shifts into the MSB of the accumulator (shift right).
  - opa and opb shift right; carry ← the bit's carry-out; cnt increments.
  - The edge that processes bit WIDTH−1 is the last RUN edge. On it, sum ← final accumulator, cout ← bit carry-out, ovf ← carry-in of that bit XOR its carry-out, done ← 1, busy ← 0, and the FSM returns to IDLE.
- sum, cout and ovf change only on the completion edge. They are stable at all other times, including throughout the next operation.
- start while busy=1 is ignored and not queued.
- start in the cycle where done=1 is accepted, because the FSM is already in IDLE. done still deasserts on the next edge.
- Arithmetic is modulo 2^WIDTH. cnt is $clog2(WIDTH)+1 bits wide, so WIDTH=1 is legal.

## Timing
- Reset (async assert, any state): FSM = IDLE; busy, done and cout = 0; sum = 0; ovf = 0; cnt, carry and operand registers = 0.
- Reset deassertion is synchronised externally. The first active edge after release may accept start.
- Accept edge E0 → busy high from E0 to E_WIDTH.
- done is high for exactly the cycle between E_WIDTH and E_WIDTH+1. Latency from accept to done is WIDTH cycles.
- Back-to-back throughput is one result per WIDTH+1 cycles, when start is held or re-asserted during the done cycle.
- Reset mid-RUN aborts the operation with no done pulse. Outputs take their reset values.
- There are no combinational paths from inputs to outputs; every output is a register.

## Structure
- Package serial_add_pkg holds:
  - state_t enum {IDLE, RUN}.
  - A localparam helper for the cnt width.
- Sub-module fa_bit is the combinational one-bit full adder (a, b, ci → s, co). It is instantiated once. It is kept separate so the datapath can be verified standalone.
- The controller holds the FSM, cnt, the operand shift registers, the carry register and the result registers.

## Test plan
- Add, WIDTH=8: a=0x5A, b=0x3C, cin=0 → at done: sum=0x96, cout=0, ovf=1. done arrives 8 cycles after accept; busy is high for those 8 cycles.
- Carry wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. With cin=1 → sum=0x01, cout=1.
- Subtract: sub=1, a=0x10, b=0x20 → sum=0xF0, cout=0, ovf=0. With a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
- Handshake:
  - Pulse start with new operands at cycle 3 of a RUN → ignored; the first result is unaffected and no second done appears.
  - Assert start during the done cycle → the second operation is accepted, and its done comes WIDTH cycles later.
- Reset mid-op: assert rst_n=0 at cycle 4 of RUN → busy, done, sum, cout and ovf drop to 0 immediately; no done follows. A fresh start then completes correctly.
- WIDTH=1 build: a=1, b=1, cin=1 → sum=1, cout=1, ovf=0 (carry into the single bit is 1, carry out is 1). done arrives 1 cycle after accept.
